// File: rtl/my_dmux_router.sv
// my_dmux_router: buffered, handshaked 1-to-2 stream router.
// Each accepted input word is steered by in_sel into one of two
// independent circular FIFOs (0 = channel A, 1 = channel B). Each channel
// presents its head word with a valid/ready handshake and its occupancy.
//
// Ports (top):
//   clk, reset            single clock, synchronous active-high reset
//   in_data/in_sel        input word and its destination
//   in_valid/in_ready     input handshake (ready depends on in_sel + counts)
//   a_data/a_valid/a_ready, a_count   channel A head, handshake, occupancy
//   b_data/b_valid/b_ready, b_count   channel B head, handshake, occupancy

// Single circular FIFO used for each router channel.
//   push     write wr_data this cycle (caller guarantees not full)
//   rd_ready consumer takes the head (ignored while empty)
//   rd_data  head word (combinational read of registered storage)
//   rd_valid FIFO non-empty
//   count    occupancy 0..DEPTH
module my_dmux_router_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             pop;

  assign rd_valid = (cnt != '0);
  assign rd_data  = mem[rd_ptr];
  assign count    = cnt;
  assign pop      = rd_valid & rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop && !push) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end
endmodule

module my_dmux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         b_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic a_push;
  logic b_push;

  // Ready looks only at the selected channel's occupancy: a full selected
  // channel stalls the input even if the other channel has room, and the
  // consumer readies never feed back combinationally into in_ready.
  assign in_ready = in_sel ? (b_count != FULL) : (a_count != FULL);
  assign a_push   = in_valid & in_ready & ~in_sel;
  assign b_push   = in_valid & in_ready &  in_sel;

  my_dmux_router_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_a (
    .clk      (clk),
    .reset    (reset),
    .push     (a_push),
    .wr_data  (in_data),
    .rd_ready (a_ready),
    .rd_data  (a_data),
    .rd_valid (a_valid),
    .count    (a_count)
  );

  my_dmux_router_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_b (
    .clk      (clk),
    .reset    (reset),
    .push     (b_push),
    .wr_data  (in_data),
    .rd_ready (b_ready),
    .rd_data  (b_data),
    .rd_valid (b_valid),
    .count    (b_count)
  );
endmodule

// File: tb/tb_my_dmux_router.sv
// Directed self-checking bench for my_dmux_router (WIDTH=8, DEPTH=4).
module tb_my_dmux_router;
  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] a_count;
  logic [2:0] b_count;

  int tests;
  int failed;

  my_dmux_router #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    logic will_push;

    tests    = 0;
    failed   = 0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_sel   = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset held two cycles with a pending push: nothing is stored.
    tick();
    tick();
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data",  a_data,  0);
    chk("rst_b_data",  b_data,  0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Routing; also confirm no same-cycle bypass into an empty FIFO.
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_sel   = 1'b0;
    #1;
    chk("nobypass_a_valid", a_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("lat1_a_valid", a_valid, 1);
    chk("lat1_b_valid", b_valid, 0);
    push(8'h22, 1'b1);
    push(8'h33, 1'b0);
    chk("route_a_count", a_count, 2);
    chk("route_b_count", b_count, 1);
    chk("route_a_data",  a_data,  8'h11);
    chk("route_b_data",  b_data,  8'h22);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("route_pop_a_data",  a_data,  8'h33);
    chk("route_pop_a_count", a_count, 1);
    chk("route_pop_b_count", b_count, 1);
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    b_ready = 1'b0;
    chk("drain_a_count", a_count, 0);
    chk("drain_b_count", b_count, 0);
    chk("drain_b_valid", b_valid, 0);

    // Full / head-of-line blocking on A.
    push(8'h41, 1'b0);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    push(8'h44, 1'b0);
    chk("full_a_count", a_count, 4);
    in_sel = 1'b0;
    #1;
    chk("full_ready_sel0", in_ready, 0);
    in_sel = 1'b1;
    #1;
    chk("full_ready_sel1", in_ready, 1);
    in_sel   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h45;
    tick();
    in_valid = 1'b0;
    chk("full_stall_a_count", a_count, 4);
    chk("full_stall_b_count", b_count, 0);
    chk("full_stall_a_data",  a_data,  8'h41);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("unfull_a_count", a_count, 3);
    chk("unfull_ready",   in_ready, 1);
    chk("unfull_a_data",  a_data,  8'h42);
    a_ready = 1'b1;
    tick();
    chk("order_a_data_43", a_data, 8'h43);
    tick();
    chk("order_a_data_44", a_data, 8'h44);
    tick();
    a_ready = 1'b0;
    chk("full_drain_a_count", a_count, 0);
    chk("full_drain_a_valid", a_valid, 0);

    // Simultaneous push and pop on A.
    push(8'h51, 1'b0);
    push(8'h52, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h53;
    in_sel   = 1'b0;
    a_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_a_count", a_count, 2);
    chk("pp_a_data",  a_data,  8'h52);
    tick();
    chk("pp_next_a_data",  a_data,  8'h53);
    chk("pp_next_a_count", a_count, 1);
    tick();
    a_ready = 1'b0;
    chk("pp_drain_a_count", a_count, 0);

    // Stream 0x00..0x0F through B with b_ready toggling; wraps pointers.
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 16 && cyc < 200) begin
      in_valid = (sent < 16);
      in_data  = 8'(sent);
      in_sel   = 1'b1;
      b_ready  = cyc[0];
      #1;
      will_push = in_valid & in_ready;
      if (b_valid && b_ready) begin
        chk("stream_b_data", b_data, rcv);
        rcv++;
      end
      if (will_push) sent++;
      tick();
      chk("stream_b_count_le4", (b_count <= 3'd4), 1);
      cyc++;
    end
    in_valid = 1'b0;
    b_ready  = 1'b0;
    chk("stream_rcv_total", rcv, 16);
    chk("stream_end_b_count", b_count, 0);
    chk("stream_a_untouched", a_count, 0);

    // Mid-operation reset discards buffered words and the concurrent push.
    push(8'h61, 1'b0);
    push(8'h62, 1'b0);
    push(8'h63, 1'b0);
    push(8'h71, 1'b1);
    push(8'h72, 1'b1);
    chk("mid_pre_a_count", a_count, 3);
    chk("mid_pre_b_count", b_count, 2);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h64;
    in_sel   = 1'b0;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_a_count", a_count, 0);
    chk("mid_b_count", b_count, 0);
    chk("mid_a_valid", a_valid, 0);
    chk("mid_b_valid", b_valid, 0);
    chk("mid_a_data",  a_data,  0);
    chk("mid_b_data",  b_data,  0);
    tick();
    chk("mid_push_lost", a_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
